// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The master issues operands; the slave (the divider) returns results.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 10
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Quot;
   logic [WIDTH-1:0] Rem;
   logic             div_by_zero;

   modport master (
      output start, is_signed, A, B,
      input  busy, done, Quot, Rem, div_by_zero
   );

   modport slave (
      input  start, is_signed, A, B,
      output busy, done, Quot, Rem, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// One-bit-per-cycle restoring divider, unsigned or two's-complement signed,
// with a start/busy/done handshake and a divide-by-zero flag.
module seq_divider #(
   parameter int unsigned WIDTH = 10
) (
   input logic          clk,
   input logic          rst_n,
   seq_divider_if.slave bus
);
   localparam int unsigned MSB   = WIDTH - 1;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CALC   = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH:0]   p_q, p_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic             zero_q, zero_d;
   logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;

   logic [WIDTH:0]   p_sh, t;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             unused_p_msb;

   // The restored partial remainder is always below the divisor, so its top bit stays 0.
   assign unused_p_msb = p_q[WIDTH];

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.Quot        = quot_q;
   assign bus.Rem         = rem_q;
   assign bus.div_by_zero = dbz_q;

   // State register and all datapath/output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      zero_d  = zero_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;

      a_mag = (bus.is_signed && bus.A[MSB]) ? (~bus.A + WIDTH'(1)) : bus.A;
      b_mag = (bus.is_signed && bus.B[MSB]) ? (~bus.B + WIDTH'(1)) : bus.B;
      p_sh  = {p_q[WIDTH-1:0], a_q[MSB]};
      t     = p_sh - {1'b0, b_q};

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               busy_d  = 1'b1;
               p_d     = '0;
               cnt_d   = '0;
               q_neg_d = bus.is_signed & (bus.A[MSB] ^ bus.B[MSB]);
               r_neg_d = bus.is_signed & bus.A[MSB];
               if (bus.B == '0) begin
                  // Skip the datapath; keep raw A to report as the remainder
                  zero_d  = 1'b1;
                  a_d     = bus.A;
                  b_d     = '0;
                  state_d = FINISH;
               end else begin
                  zero_d  = 1'b0;
                  a_d     = a_mag;
                  b_d     = b_mag;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            a_d   = {a_q[MSB-1:0], ~t[WIDTH]};
            p_d   = t[WIDTH] ? p_sh : t;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (zero_q) begin
               quot_d = '1;
               rem_d  = a_q;
               dbz_d  = 1'b1;
            end else begin
               quot_d = q_neg_q ? (~a_q + WIDTH'(1)) : a_q;
               rem_d  = r_neg_q ? (~p_q[WIDTH-1:0] + WIDTH'(1)) : p_q[WIDTH-1:0];
               dbz_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end
endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle, parametrised integer divider for the calculator datapath, replacing the single-cycle combinational division unit. It computes quotient and remainder with a one-bit-per-cycle restoring algorithm and supports unsigned and two's-complement signed operands, selected per operation. It has a start/busy/done handshake and flags divide-by-zero, so the calculator control FSM can issue a division and wait for its result.

## Interface
- WIDTH, 10: operand, quotient and remainder width in bits; legal range ≥ 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement operation, 0 = unsigned; sampled with start.
- A  in  WIDTH  dividend; sampled with start.
- B  in  WIDTH  divisor; sampled with start.
- busy  out  1  high from the edge that accepts start until the edge that raises done.
- done  out  1  single-cycle pulse; Quot, Rem and div_by_zero are valid from this cycle.
- Quot  out  WIDTH  registered quotient; held until the next done.
- Rem  out  WIDTH  registered remainder; held until the next done.
- div_by_zero  out  1  registered; updated with each done.

## Operation
- States are IDLE, CALC and FINISH.
- IDLE → CALC: on start=1 with B≠0.
  - Latch the magnitude of A into the dividend/quotient shift register a_q and the magnitude of B into b_q.
  - In signed mode, magnitude = two's-complement negate if the MSB is 1. The most negative value maps to 2^(WIDTH-1), which fits unsigned.
  - Latch the result signs: q_neg = is_signed & (A[MSB] ^ B[MSB]) and r_neg = is_signed & A[MSB].
  - Clear the partial remainder p_q (WIDTH+1 bits) and the iteration counter.
- IDLE → FINISH: on start=1 with B=0. The quotient/remainder datapath is not run. FINISH loads Quot = all ones, Rem = A (raw) and div_by_zero = 1.
- CALC performs one iteration per cycle, exactly WIDTH cycles:
  - p = {p_q[WIDTH-1:0], a_q[MSB]}; shift a_q left by one.
  - t = p − {1'b0, b_q} on WIDTH+1 bits.
  - If t[WIDTH] = 1 (negative): keep p and set quotient bit a_q[0] = 0. Otherwise: p = t and a_q[0] = 1.
  - The sign test uses bit WIDTH, not bit WIDTH−1.
- CALC → FINISH: after the WIDTH-th iteration.
- FINISH, for a non-zero divisor:
  - Quot = q_neg ? −a_q : a_q, truncated to WIDTH.
  - Rem = r_neg ? −p_q[WIDTH-1:0] : p_q[WIDTH-1:0].
  - div_by_zero = 0.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Signed overflow: most-negative / −1 yields Quot = most-negative (wraps) and Rem = 0. There is no flag.
- FINISH → IDLE: unconditionally, with done = 1 and busy = 0 in the following cycle.
- start while busy is ignored; a start asserted in the done cycle is accepted, because the FSM is already in IDLE.

## Timing
- Reset, asynchronous on rst_n=0: state = IDLE, and busy, done, Quot, Rem, div_by_zero, a_q, p_q, b_q and the counter all = 0.
- A reset during CALC or FINISH aborts the operation. No done is produced, and the outputs read 0.
- The accepting edge is E0. busy is high after E0.
- Normal division: FINISH is entered at E_WIDTH. Outputs and done=1 appear after E(WIDTH+1), and busy falls at that same edge. Latency is WIDTH+1 cycles.
- Divide by zero: FINISH is entered at E0. done and the outputs appear after E1, a latency of 1 cycle.
- done is high for exactly one cycle and is never high at the same time as busy.
- Back-to-back: the earliest next start is the done cycle. Throughput is one division per WIDTH+2 cycles.

## Test plan
- Unsigned, WIDTH=10, A=1000, B=7 → Quot=142, Rem=6, div_by_zero=0. done arrives exactly 11 cycles after the start edge, with busy high for those 11 cycles.
- Unsigned boundary, A=1023, B=1 → Quot=1023, Rem=0. Then A=5, B=1023 → Quot=0, Rem=5. This second case checks that the sign test uses bit WIDTH.
- Signed, A=−100 (0x39C), B=7 → Quot=−14 (0x3F2), Rem=−2 (0x3FE). Also A=100, B=−7 → Quot=0x3F2, Rem=2.
- Signed overflow, A=−512 (0x200), B=−1 (0x3FF) → Quot=0x200, Rem=0, div_by_zero=0.
- Divide by zero, A=55, B=0, either mode → done one cycle after the accepting edge, with Quot=0x3FF, Rem=55 and div_by_zero=1. The next valid division clears div_by_zero.
- Two further cases:
  - Pulse start with new operands during CALC: the pulse is ignored and the first result is unchanged.
  - Assert rst_n=0 at cycle 5 of CALC: the outputs go to 0 immediately and no done follows.
